// File: rtl/alu_cmd_sequencer.sv
// Command FIFO plus issue/capture sequencer around a registered ALU.
// Commands are issued one at a time; flag-qualified results are returned over valid/ready.
module alu_cmd_sequencer #(
  parameter int INDATA_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [INDATA_WIDTH-1:0]         cmd_a,
  input  logic [INDATA_WIDTH-1:0]         cmd_b,
  input  logic [3:0]                      cmd_func,
  output logic [INDATA_WIDTH-1:0]         alu_a,
  output logic [INDATA_WIDTH-1:0]         alu_b,
  output logic [3:0]                      alu_fun,
  input  logic [2*INDATA_WIDTH-1:0]       arith_out,
  input  logic                            carry_out,
  input  logic                            arith_flag,
  input  logic [INDATA_WIDTH-1:0]         logic_out,
  input  logic                            logic_flag,
  input  logic [INDATA_WIDTH-1:0]         shift_out,
  input  logic                            shift_flag,
  input  logic [2:0]                      cmp_out,
  input  logic                            cmp_flag,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic [2*INDATA_WIDTH-1:0]       res_data,
  output logic                            res_carry,
  output logic [1:0]                      res_class,
  output logic                            res_err,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);

  localparam int W  = INDATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPT, HOLD} state_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   func;
  } cmd_t;

  cmd_t          mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  state_t          state_q;
  logic [W-1:0]    alu_a_q, alu_b_q;
  logic [3:0]      alu_fun_q;
  logic            res_valid_q, res_carry_q, res_err_q;
  logic [2*W-1:0]  res_data_q;
  logic [1:0]      res_class_q;

  logic            res_carry_d, res_err_d;
  logic [2*W-1:0]  res_data_d;
  logic [1:0]      res_class_d;

  logic  fifo_nonempty, push, pop;
  cmd_t  head;

  assign cmd_ready     = (count_q < CW'(FIFO_DEPTH));
  assign fifo_nonempty = (count_q != '0);
  assign push          = cmd_valid && cmd_ready;
  assign pop           = fifo_nonempty &&
                         ((state_q == IDLE) || ((state_q == HOLD) && res_ready));
  assign head          = mem_q[rd_ptr_q];

  // NOTE: FIFO storage has no reset; pointers and count alone define validity, and
  // leaving the array out of the reset keeps it mappable to plain RAM.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= '{a: cmd_a, b: cmd_b, func: cmd_func};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    res_data_d  = '0;
    res_class_d = 2'd0;
    res_carry_d = 1'b0;
    res_err_d   = 1'b1;
    case ({arith_flag, logic_flag, cmp_flag, shift_flag})
      4'b1000: begin
        res_data_d  = arith_out;
        res_carry_d = carry_out;
        res_err_d   = 1'b0;
      end
      4'b0100: begin
        res_data_d  = {{W{1'b0}}, logic_out};
        res_class_d = 2'd1;
        res_err_d   = 1'b0;
      end
      4'b0010: begin
        res_data_d  = {{(2*W-3){1'b0}}, cmp_out};
        res_class_d = 2'd2;
        res_err_d   = 1'b0;
      end
      4'b0001: begin
        res_data_d  = {{W{1'b0}}, shift_out};
        res_class_d = 2'd3;
        res_err_d   = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_fun_q   <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_class_q <= 2'd0;
      res_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            alu_a_q   <= head.a;
            alu_b_q   <= head.b;
            alu_fun_q <= head.func;
            state_q   <= ISSUE;
          end
        end
        ISSUE: state_q <= CAPT;
        CAPT: begin
          res_data_q  <= res_data_d;
          res_class_q <= res_class_d;
          res_carry_q <= res_carry_d;
          res_err_q   <= res_err_d;
          res_valid_q <= 1'b1;
          state_q     <= HOLD;
        end
        HOLD: begin
          // Back-to-back issue straight from HOLD keeps throughput at one per 3 cycles.
          if (res_ready) begin
            res_valid_q <= 1'b0;
            if (pop) begin
              alu_a_q   <= head.a;
              alu_b_q   <= head.b;
              alu_fun_q <= head.func;
              state_q   <= ISSUE;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_fun    = alu_fun_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_carry  = res_carry_q;
  assign res_class  = res_class_q;
  assign res_err    = res_err_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a small registered ALU model.
// Func codes: 0 add, 1 and, 2 compare, 3 shl1, 4 arith+logic flags, 6 no flags.
module tb_alu_cmd_sequencer;

  localparam int W = 16;

  logic          CLK, RST;
  logic          cmd_valid, cmd_ready;
  logic [W-1:0]  cmd_a, cmd_b;
  logic [3:0]    cmd_func;
  logic [W-1:0]  alu_a, alu_b;
  logic [3:0]    alu_fun;
  logic [2*W-1:0] arith_out;
  logic          carry_out, arith_flag, logic_flag, shift_flag, cmp_flag;
  logic [W-1:0]  logic_out, shift_out;
  logic [2:0]    cmp_out;
  logic          res_valid, res_ready, res_carry, res_err;
  logic [2*W-1:0] res_data;
  logic [1:0]    res_class;
  logic [2:0]    fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  alu_cmd_sequencer #(.INDATA_WIDTH(W), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_func(cmd_func),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .arith_out(arith_out), .carry_out(carry_out), .arith_flag(arith_flag),
    .logic_out(logic_out), .logic_flag(logic_flag),
    .shift_out(shift_out), .shift_flag(shift_flag),
    .cmp_out(cmp_out), .cmp_flag(cmp_flag),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_carry(res_carry),
    .res_class(res_class), .res_err(res_err),
    .fifo_count(fifo_count)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Registered ALU model: samples alu_* on the rising edge.
  always @(posedge CLK) begin
    logic [W:0] sum;
    sum = {1'b0, alu_a} + {1'b0, alu_b};
    arith_out  <= {{(W-1){1'b0}}, sum};
    carry_out  <= sum[W];
    logic_out  <= alu_a & alu_b;
    shift_out  <= alu_a << 1;
    cmp_out    <= (alu_a < alu_b) ? 3'd1 : (alu_a == alu_b) ? 3'd2 : 3'd4;
    arith_flag <= (alu_fun == 4'd0) || (alu_fun == 4'd4);
    logic_flag <= (alu_fun == 4'd1) || (alu_fun == 4'd4);
    cmp_flag   <= (alu_fun == 4'd2);
    shift_flag <= (alu_fun == 4'd3);
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] f);
    cmd_a = a; cmd_b = b; cmd_func = f; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !res_valid; i++) tick();
    check({tag, "_valid"}, 64'(res_valid), 64'd1);
  endtask

  task automatic take();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic run_one(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] f, input logic [63:0] e_data, input logic [1:0] e_class,
                         input logic e_carry, input logic e_err);
    push(a, b, f);
    wait_valid(tag);
    check({tag, "_data"},  64'(res_data),  e_data);
    check({tag, "_class"}, 64'(res_class), 64'(e_class));
    check({tag, "_carry"}, 64'(res_carry), 64'(e_carry));
    check({tag, "_err"},   64'(res_err),   64'(e_err));
    take();
  endtask

  initial begin
    int k, last;
    RST = 1'b1; res_ready = 1'b0;
    cmd_valid = 1'b1; cmd_a = 16'h1234; cmd_b = 16'h5678; cmd_func = 4'd0;

    // Reset with a command offered: nothing may be accepted.
    repeat (3) tick();
    check("rst_count",  64'(fifo_count), 64'd0);
    check("rst_ready",  64'(cmd_ready),  64'd1);
    check("rst_valid",  64'(res_valid),  64'd0);
    check("rst_alu_a",  64'(alu_a),      64'd0);
    check("rst_alu_b",  64'(alu_b),      64'd0);
    check("rst_alu_fun",64'(alu_fun),    64'd0);
    check("rst_data",   64'(res_data),   64'd0);
    check("rst_class",  64'(res_class),  64'd0);
    check("rst_carry",  64'(res_carry),  64'd0);
    check("rst_err",    64'(res_err),    64'd0);
    cmd_valid = 1'b0;
    RST = 1'b0;
    tick();
    check("rel_count", 64'(fifo_count), 64'd0);
    check("rel_ready", 64'(cmd_ready),  64'd1);

    // Single add: 3-edge latency from accept to res_valid.
    check("add_ready", 64'(cmd_ready), 64'd1);
    push(16'd15, 16'd10, 4'd0);                       // E0
    check("add_cnt_e0", 64'(fifo_count), 64'd1);
    tick();                                           // E1
    check("add_cnt_e1", 64'(fifo_count), 64'd0);
    check("add_alu_a",  64'(alu_a),   64'd15);
    check("add_alu_b",  64'(alu_b),   64'd10);
    check("add_alu_fun",64'(alu_fun), 64'd0);
    check("add_valid_e1", 64'(res_valid), 64'd0);
    tick();                                           // E2
    check("add_valid_e2", 64'(res_valid), 64'd0);
    tick();                                           // E3
    check("add_valid_e3", 64'(res_valid), 64'd1);
    check("add_data",  64'(res_data),  64'd25);
    check("add_class", 64'(res_class), 64'd0);
    check("add_carry", 64'(res_carry), 64'd0);
    check("add_err",   64'(res_err),   64'd0);
    take();
    check("add_done_valid", 64'(res_valid), 64'd0);

    // Back-pressure: one in HOLD, four in the FIFO, sixth refused.
    for (int i = 1; i <= 6; i++) begin
      cmd_a = 16'(100 + i); cmd_b = 16'(i); cmd_func = 4'd0; cmd_valid = 1'b1;
      check($sformatf("bp_ready%0d", i), 64'(cmd_ready), (i <= 5) ? 64'd1 : 64'd0);
      tick();
    end
    check("bp_full_cnt",   64'(fifo_count), 64'd4);
    check("bp_full_ready", 64'(cmd_ready),  64'd0);
    check("bp_hold_valid", 64'(res_valid),  64'd1);
    check("bp_hold_data",  64'(res_data),   64'd102);
    repeat (3) tick();
    check("bp_stable_cnt",   64'(fifo_count), 64'd4);
    check("bp_stable_valid", 64'(res_valid),  64'd1);
    check("bp_stable_data",  64'(res_data),   64'd102);
    check("bp_stable_class", 64'(res_class),  64'd0);
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    k = 0; last = 0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      if (res_valid) begin
        check($sformatf("bp_res%0d", k), 64'(res_data), 64'(100 + 2 * (k + 1)));
        if (k > 0) check($sformatf("bp_gap%0d", k), 64'(cyc - last), 64'd3);
        last = cyc;
        k++;
      end
      tick();
    end
    check("bp_nres", 64'(k), 64'd5);
    repeat (4) tick();
    check("bp_no_extra", 64'(res_valid),  64'd0);
    check("bp_empty",    64'(fifo_count), 64'd0);
    res_ready = 1'b0;

    // Class mapping, carry gating and flag errors.
    run_one("logic", 16'hFFFF, 16'h0002, 4'd1, 64'd2, 2'd1, 1'b0, 1'b0);
    run_one("cmp",   16'd5,    16'd5,    4'd2, 64'd2, 2'd2, 1'b0, 1'b0);
    run_one("shift", 16'h0002, 16'hFFFF, 4'd3, 64'd4, 2'd3, 1'b0, 1'b0);
    run_one("carry", 16'hFFFF, 16'h0001, 4'd0, 64'h10000, 2'd0, 1'b1, 1'b0);
    run_one("err2",  16'd3,    16'd4,    4'd4, 64'd0, 2'd0, 1'b0, 1'b1);
    run_one("err0",  16'd3,    16'd4,    4'd6, 64'd0, 2'd0, 1'b0, 1'b1);

    // Mid-operation reset while in CAPT with three commands queued.
    for (int i = 1; i <= 5; i++) push(16'(200 + i), 16'd0, 4'd0);
    check("mr_hold_valid", 64'(res_valid),  64'd1);
    check("mr_hold_data",  64'(res_data),   64'd201);
    check("mr_full_cnt",   64'(fifo_count), 64'd4);
    take();                                           // HOLD -> ISSUE, pop
    tick();                                           // ISSUE -> CAPT
    check("mr_capt_cnt", 64'(fifo_count), 64'd3);
    #1 RST = 1'b1;
    #1;
    check("mr_valid", 64'(res_valid),  64'd0);
    check("mr_cnt",   64'(fifo_count), 64'd0);
    check("mr_data",  64'(res_data),   64'd0);
    check("mr_alu_a", 64'(alu_a),      64'd0);
    check("mr_ready", 64'(cmd_ready),  64'd1);
    tick();
    RST = 1'b0;
    repeat (6) tick();
    check("mr_no_stale", 64'(res_valid),  64'd0);
    check("mr_post_cnt", 64'(fifo_count), 64'd0);
    run_one("recover", 16'd7, 16'd8, 4'd0, 64'd15, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
